a2mem_switch_ctrl: RTL and testbench

A2MEM_SWITCH_CTRL -- requirements
Module: a2mem_switch_ctrl

---
 rtl/a2mem_switch_ctrl.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_a2mem_switch_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/a2mem_switch_ctrl.sv
// Apple II / IIgs soft-switch decoder with keyboard FIFO.
// Latency: switches, SLOTROM, INTC8ROM and aux_mem register one clk_logic edge after the strobe.
//          keycode is combinational from FIFO state; keypress_strobe and key_ready are registered.
// Backpressure: key_ready drops when the FIFO is full; the bus side is never stalled.
//
// Ports:
//   clk_logic, system_reset      - single clock, async active-high reset
//   addr, data, rw_n             - Apple II bus, qualified by data_in_strobe (one pulse per bus cycle)
//   key_valid, key_code, key_ready - keyboard push interface (push on key_valid && key_ready)
//   TEXT_MODE .. AN3             - C050-C05F video/annunciator switches
//   STORE80 .. ALTCHAR           - C000-C00F memory management switches (write only)
//   INTC8ROM, SLOTROM            - expansion ROM ownership tracking
//   MONOCHROME_*, SHRG_MODE, LINEARIZE_MODE, *_COLOR - IIgs video registers
//   aux_mem                      - registered aux/main bank select for the current access
//   keycode, keypress_strobe     - keyboard data (bit 7 = key pending) and new-head pulse
module a2mem_switch_ctrl #(
  parameter int KEY_FIFO_DEPTH = 4,
  parameter int ENABLE_IIGS    = 1
) (
  input  logic        clk_logic,
  input  logic        system_reset,
  input  logic [15:0] addr,
  input  logic [7:0]  data,
  input  logic        rw_n,
  input  logic        data_in_strobe,
  input  logic        key_valid,
  input  logic [6:0]  key_code,
  output logic        key_ready,
  output logic        TEXT_MODE,
  output logic        MIXED_MODE,
  output logic        PAGE2,
  output logic        HIRES_MODE,
  output logic        AN0,
  output logic        AN1,
  output logic        AN2,
  output logic        AN3,
  output logic        STORE80,
  output logic        RAMRD,
  output logic        RAMWRT,
  output logic        INTCXROM,
  output logic        ALTZP,
  output logic        SLOTC3ROM,
  output logic        COL80,
  output logic        ALTCHAR,
  output logic        INTC8ROM,
  output logic        MONOCHROME_MODE,
  output logic        MONOCHROME_DHIRES_MODE,
  output logic        SHRG_MODE,
  output logic        LINEARIZE_MODE,
  output logic        aux_mem,
  output logic        keypress_strobe,
  output logic [2:0]  SLOTROM,
  output logic [3:0]  TEXT_COLOR,
  output logic [3:0]  BACKGROUND_COLOR,
  output logic [3:0]  BORDER_COLOR,
  output logic [7:0]  keycode
);

  localparam int AW = (KEY_FIFO_DEPTH > 1) ? $clog2(KEY_FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(KEY_FIFO_DEPTH);

  // Bit i of each vector is the switch addressed by pair i (addresses 2i / 2i+1).
  // mmu: STORE80, RAMRD, RAMWRT, INTCXROM, ALTZP, SLOTC3ROM, COL80, ALTCHAR
  // vid: TEXT_MODE, MIXED_MODE, PAGE2, HIRES_MODE, AN0, AN1, AN2, AN3
  localparam logic [7:0] MMU_RST = 8'h00;
  localparam logic [7:0] VID_RST = 8'h01;

  logic [7:0] mmu_sw_q, mmu_sw_d;
  logic [7:0] vid_sw_q, vid_sw_d;
  logic [2:0] slotrom_q, slotrom_d;
  logic       intc8rom_q, intc8rom_d;
  logic       aux_q, aux_d;
  logic       mono_q, mono_d;
  logic       shrg_q, shrg_d;
  logic       lin_q, lin_d;
  logic       mdh_q, mdh_d;
  logic [3:0] text_color_q, text_color_d;
  logic [3:0] bg_color_q, bg_color_d;
  logic [3:0] border_color_q, border_color_d;

  // Keyboard FIFO state
  logic [6:0]    key_mem_q [KEY_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [6:0]    last_key_q, last_key_d;
  logic          key_ready_q, key_ready_d;
  logic          kp_strobe_q, kp_strobe_d;

  logic       push, pop, fifo_nonempty;
  logic [6:0] head_key;

  // Pre-edge switch values used for decode
  logic store80, ramrd, ramwrt, intcxrom, altzp, slotc3rom, page2, hires;
  assign store80   = mmu_sw_q[0];
  assign ramrd     = mmu_sw_q[1];
  assign ramwrt    = mmu_sw_q[2];
  assign intcxrom  = mmu_sw_q[3];
  assign altzp     = mmu_sw_q[4];
  assign slotc3rom = mmu_sw_q[5];
  assign page2     = vid_sw_q[2];
  assign hires     = vid_sw_q[3];

  logic acc_c00x, acc_c01x, acc_c05x, acc_slot, acc_c3xx;
  assign acc_c00x = (addr[15:4] == 12'hC00);
  assign acc_c01x = (addr[15:4] == 12'hC01);
  assign acc_c05x = (addr[15:4] == 12'hC05);
  // Cn00-CnFF for n = 1..7
  assign acc_slot = (addr[15:12] == 4'hC) && !addr[11] && (addr[10:8] != 3'd0);
  assign acc_c3xx = (addr[15:8] == 8'hC3);

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  always_comb begin
    mmu_sw_d       = mmu_sw_q;
    vid_sw_d       = vid_sw_q;
    slotrom_d      = slotrom_q;
    intc8rom_d     = intc8rom_q;
    aux_d          = aux_q;
    mono_d         = mono_q;
    shrg_d         = shrg_q;
    lin_d          = lin_q;
    mdh_d          = mdh_q;
    text_color_d   = text_color_q;
    bg_color_d     = bg_color_q;
    border_color_d = border_color_q;

    if (data_in_strobe) begin
      // Memory management switches only respond to writes
      if (acc_c00x && !rw_n) begin
        mmu_sw_d[addr[3:1]] = addr[0];
      end
      if (acc_c05x) begin
        vid_sw_d[addr[3:1]] = addr[0];
      end

      if ((ENABLE_IIGS != 0) && !rw_n) begin
        case (addr)
          16'hC021: mono_d = data[7];
          16'hC022: begin
            text_color_d = data[7:4];
            bg_color_d   = data[3:0];
          end
          16'hC029: begin
            shrg_d = data[7];
            lin_d  = data[6];
            mdh_d  = data[5];
          end
          16'hC034: border_color_d = data[3:0];
          default: ;
        endcase
      end

      if (acc_slot && !intcxrom) begin
        slotrom_d = addr[10:8];
      end
      if (acc_c3xx && !intcxrom && !slotc3rom) begin
        intc8rom_d = 1'b1;
      end
      // CFFF releases the shared C800 space and wins over a C3xx claim
      if (addr == 16'hCFFF) begin
        intc8rom_d = 1'b0;
      end

      if (addr < 16'h0200) begin
        aux_d = altzp;
      end else if (store80 && (addr[15:10] == 6'b000001)) begin
        // 0400-07FF: text page 1 steered by PAGE2 under 80STORE
        aux_d = page2;
      end else if (store80 && hires && (addr[15:13] == 3'b001)) begin
        // 2000-3FFF: hires page 1 steered by PAGE2 under 80STORE+HIRES
        aux_d = page2;
      end else if (addr < 16'hC000) begin
        aux_d = rw_n ? ramrd : ramwrt;
      end else begin
        aux_d = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Keyboard FIFO
  // ---------------------------------------------------------------------------
  assign fifo_nonempty = (count_q != '0);
  assign head_key      = key_mem_q[rd_ptr_q];
  assign push          = key_valid && key_ready_q;
  assign pop           = data_in_strobe && acc_c01x && fifo_nonempty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    last_key_d  = last_key_q;
    count_d     = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      last_key_d = head_key;
    end
    key_ready_d = (count_d != FULL_CNT);
    // A new head appears when an empty FIFO receives a key, or a pop exposes
    // the next entry (including a key pushed on the same edge).
    kp_strobe_d = (push && !fifo_nonempty) || (pop && (count_d != '0));
  end

  // Storage needs no reset: entries are only visible while counted as valid.
  always_ff @(posedge clk_logic) begin
    if (push) begin
      key_mem_q[wr_ptr_q] <= key_code;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_logic or posedge system_reset) begin
    if (system_reset) begin
      mmu_sw_q       <= MMU_RST;
      vid_sw_q       <= VID_RST;
      slotrom_q      <= 3'd0;
      intc8rom_q     <= 1'b0;
      aux_q          <= 1'b0;
      mono_q         <= 1'b0;
      shrg_q         <= 1'b0;
      lin_q          <= 1'b0;
      mdh_q          <= 1'b0;
      text_color_q   <= 4'hF;
      bg_color_q     <= 4'h6;
      border_color_q <= 4'h6;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      last_key_q     <= 7'd0;
      key_ready_q    <= 1'b1;
      kp_strobe_q    <= 1'b0;
    end else begin
      mmu_sw_q       <= mmu_sw_d;
      vid_sw_q       <= vid_sw_d;
      slotrom_q      <= slotrom_d;
      intc8rom_q     <= intc8rom_d;
      aux_q          <= aux_d;
      mono_q         <= mono_d;
      shrg_q         <= shrg_d;
      lin_q          <= lin_d;
      mdh_q          <= mdh_d;
      text_color_q   <= text_color_d;
      bg_color_q     <= bg_color_d;
      border_color_q <= border_color_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      last_key_q     <= last_key_d;
      key_ready_q    <= key_ready_d;
      kp_strobe_q    <= kp_strobe_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign STORE80    = mmu_sw_q[0];
  assign RAMRD      = mmu_sw_q[1];
  assign RAMWRT     = mmu_sw_q[2];
  assign INTCXROM   = mmu_sw_q[3];
  assign ALTZP      = mmu_sw_q[4];
  assign SLOTC3ROM  = mmu_sw_q[5];
  assign COL80      = mmu_sw_q[6];
  assign ALTCHAR    = mmu_sw_q[7];

  assign TEXT_MODE  = vid_sw_q[0];
  assign MIXED_MODE = vid_sw_q[1];
  assign PAGE2      = vid_sw_q[2];
  assign HIRES_MODE = vid_sw_q[3];
  assign AN0        = vid_sw_q[4];
  assign AN1        = vid_sw_q[5];
  assign AN2        = vid_sw_q[6];
  assign AN3        = vid_sw_q[7];

  assign SLOTROM                = slotrom_q;
  assign INTC8ROM               = intc8rom_q;
  assign aux_mem                = aux_q;
  assign MONOCHROME_MODE        = mono_q;
  assign MONOCHROME_DHIRES_MODE = mdh_q;
  assign SHRG_MODE              = shrg_q;
  assign LINEARIZE_MODE         = lin_q;
  assign TEXT_COLOR             = text_color_q;
  assign BACKGROUND_COLOR       = bg_color_q;
  assign BORDER_COLOR           = border_color_q;

  assign key_ready       = key_ready_q;
  assign keypress_strobe = kp_strobe_q;
  // Bit 7 flags a pending key; when empty the last consumed key stays visible.
  assign keycode         = {fifo_nonempty, fifo_nonempty ? head_key : last_key_q};

endmodule

// File: tb/tb_a2mem_switch_ctrl.sv
module tb_a2mem_switch_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [7:0]  data;
  logic        rw_n, stb, key_valid;
  logic [6:0]  key_code;

  logic key_ready, TEXT_MODE, MIXED_MODE, PAGE2, HIRES_MODE, AN0, AN1, AN2, AN3;
  logic STORE80, RAMRD, RAMWRT, INTCXROM, ALTZP, SLOTC3ROM, COL80, ALTCHAR, INTC8ROM;
  logic MONOCHROME_MODE, MONOCHROME_DHIRES_MODE, SHRG_MODE, LINEARIZE_MODE;
  logic aux_mem, keypress_strobe;
  logic [2:0] SLOTROM;
  logic [3:0] TEXT_COLOR, BACKGROUND_COLOR, BORDER_COLOR;
  logic [7:0] keycode;

  // Second instance with IIgs decode disabled
  logic [22:0] n_bits;
  logic        n_ready;
  logic [2:0]  n_slot;
  logic [3:0]  n_text, n_bg, n_border;
  logic [7:0]  n_keycode;

  always #5 clk = ~clk;

  a2mem_switch_ctrl #(.KEY_FIFO_DEPTH(DEPTH), .ENABLE_IIGS(1)) u_dut (
    .clk_logic(clk), .system_reset(rst), .addr(addr), .data(data), .rw_n(rw_n),
    .data_in_strobe(stb), .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
    .TEXT_MODE(TEXT_MODE), .MIXED_MODE(MIXED_MODE), .PAGE2(PAGE2), .HIRES_MODE(HIRES_MODE),
    .AN0(AN0), .AN1(AN1), .AN2(AN2), .AN3(AN3),
    .STORE80(STORE80), .RAMRD(RAMRD), .RAMWRT(RAMWRT), .INTCXROM(INTCXROM), .ALTZP(ALTZP),
    .SLOTC3ROM(SLOTC3ROM), .COL80(COL80), .ALTCHAR(ALTCHAR), .INTC8ROM(INTC8ROM),
    .MONOCHROME_MODE(MONOCHROME_MODE), .MONOCHROME_DHIRES_MODE(MONOCHROME_DHIRES_MODE),
    .SHRG_MODE(SHRG_MODE), .LINEARIZE_MODE(LINEARIZE_MODE), .aux_mem(aux_mem),
    .keypress_strobe(keypress_strobe), .SLOTROM(SLOTROM), .TEXT_COLOR(TEXT_COLOR),
    .BACKGROUND_COLOR(BACKGROUND_COLOR), .BORDER_COLOR(BORDER_COLOR), .keycode(keycode)
  );

  a2mem_switch_ctrl #(.KEY_FIFO_DEPTH(DEPTH), .ENABLE_IIGS(0)) u_dut_nogs (
    .clk_logic(clk), .system_reset(rst), .addr(addr), .data(data), .rw_n(rw_n),
    .data_in_strobe(stb), .key_valid(key_valid), .key_code(key_code), .key_ready(n_ready),
    .TEXT_MODE(n_bits[0]), .MIXED_MODE(n_bits[1]), .PAGE2(n_bits[2]), .HIRES_MODE(n_bits[3]),
    .AN0(n_bits[4]), .AN1(n_bits[5]), .AN2(n_bits[6]), .AN3(n_bits[7]),
    .STORE80(n_bits[8]), .RAMRD(n_bits[9]), .RAMWRT(n_bits[10]), .INTCXROM(n_bits[11]),
    .ALTZP(n_bits[12]), .SLOTC3ROM(n_bits[13]), .COL80(n_bits[14]), .ALTCHAR(n_bits[15]),
    .INTC8ROM(n_bits[16]), .MONOCHROME_MODE(n_bits[17]), .MONOCHROME_DHIRES_MODE(n_bits[18]),
    .SHRG_MODE(n_bits[19]), .LINEARIZE_MODE(n_bits[20]), .aux_mem(n_bits[21]),
    .keypress_strobe(n_bits[22]), .SLOTROM(n_slot), .TEXT_COLOR(n_text),
    .BACKGROUND_COLOR(n_bg), .BORDER_COLOR(n_border), .keycode(n_keycode)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: switches by name, keyboard FIFO as a queue
  // ---------------------------------------------------------------------------
  string c000_names[8] = '{"STORE80", "RAMRD", "RAMWRT", "INTCXROM",
                           "ALTZP", "SLOTC3ROM", "COL80", "ALTCHAR"};
  string c050_names[8] = '{"TEXT_MODE", "MIXED_MODE", "PAGE2", "HIRES_MODE",
                           "AN0", "AN1", "AN2", "AN3"};
  bit         m_sw[string];
  logic [2:0] m_slot;
  bit         m_intc8, m_aux, m_mono, m_shrg, m_lin, m_mdh, m_kp, m_ready;
  logic [3:0] m_text, m_bg, m_border;
  logic [6:0] m_q[$];
  logic [6:0] m_last;

  function automatic void m_reset();
    foreach (c000_names[i]) m_sw[c000_names[i]] = 1'b0;
    foreach (c050_names[i]) m_sw[c050_names[i]] = 1'b0;
    m_sw["TEXT_MODE"] = 1'b1;
    m_slot = 3'd0; m_intc8 = 1'b0; m_aux = 1'b0;
    m_mono = 1'b0; m_shrg = 1'b0; m_lin = 1'b0; m_mdh = 1'b0;
    m_text = 4'hF; m_bg = 4'h6; m_border = 4'h6;
    m_q.delete(); m_last = 7'd0; m_kp = 1'b0; m_ready = 1'b1;
  endfunction

  function automatic void model_step(input logic s, input logic [15:0] a, input logic [7:0] d,
                                     input logic rw, input logic kv, input logic [6:0] kc);
    bit p_store80, p_ramrd, p_ramwrt, p_intcx, p_altzp, p_c3rom, p_page2, p_hires;
    bit do_push, do_pop;
    int n0;
    p_store80 = m_sw["STORE80"];  p_ramrd = m_sw["RAMRD"];   p_ramwrt = m_sw["RAMWRT"];
    p_intcx   = m_sw["INTCXROM"]; p_altzp = m_sw["ALTZP"];   p_c3rom  = m_sw["SLOTC3ROM"];
    p_page2   = m_sw["PAGE2"];    p_hires = m_sw["HIRES_MODE"];
    if (s) begin
      if (a >= 16'hC000 && a <= 16'hC00F && !rw) m_sw[c000_names[int'(a - 16'hC000) / 2]] = a[0];
      if (a >= 16'hC050 && a <= 16'hC05F) m_sw[c050_names[int'(a - 16'hC050) / 2]] = a[0];
      if (!rw) begin
        if (a == 16'hC021) m_mono = d[7];
        if (a == 16'hC022) begin m_text = d[7:4]; m_bg = d[3:0]; end
        if (a == 16'hC029) begin m_shrg = d[7]; m_lin = d[6]; m_mdh = d[5]; end
        if (a == 16'hC034) m_border = d[3:0];
      end
      if (a >= 16'hC100 && a <= 16'hC7FF && !p_intcx) m_slot = 3'(int'(a - 16'hC000) / 256);
      if (a >= 16'hC300 && a <= 16'hC3FF && !p_intcx && !p_c3rom) m_intc8 = 1'b1;
      if (a == 16'hCFFF) m_intc8 = 1'b0;
      if (a < 16'h0200) m_aux = p_altzp;
      else if (a >= 16'h0400 && a <= 16'h07FF && p_store80) m_aux = p_page2;
      else if (a >= 16'h2000 && a <= 16'h3FFF && p_store80 && p_hires) m_aux = p_page2;
      else if (a <= 16'hBFFF) m_aux = rw ? p_ramrd : p_ramwrt;
      else m_aux = 1'b0;
    end
    n0 = m_q.size();
    do_push = kv && m_ready;
    do_pop  = s && a >= 16'hC010 && a <= 16'hC01F && n0 > 0;
    if (do_pop) m_last = m_q.pop_front();
    if (do_push) m_q.push_back(kc);
    m_kp    = (do_push && n0 == 0) || (do_pop && m_q.size() > 0);
    m_ready = m_q.size() < DEPTH;
  endfunction

  task automatic compare_all();
    logic [7:0] e_mmu, e_vid, e_kc;
    for (int i = 0; i < 8; i++) begin
      e_mmu[i] = m_sw[c000_names[i]];
      e_vid[i] = m_sw[c050_names[i]];
    end
    e_kc = (m_q.size() > 0) ? {1'b1, m_q[0]} : {1'b0, m_last};
    chk("mmu_sw", {ALTCHAR, COL80, SLOTC3ROM, ALTZP, INTCXROM, RAMWRT, RAMRD, STORE80}, e_mmu);
    chk("video_sw", {AN3, AN2, AN1, AN0, HIRES_MODE, PAGE2, MIXED_MODE, TEXT_MODE}, e_vid);
    chk("slot", {SLOTROM, INTC8ROM}, {m_slot, m_intc8});
    chk("aux_mem", aux_mem, m_aux);
    chk("iigs", {MONOCHROME_MODE, MONOCHROME_DHIRES_MODE, SHRG_MODE, LINEARIZE_MODE,
                 TEXT_COLOR, BACKGROUND_COLOR, BORDER_COLOR},
        {m_mono, m_mdh, m_shrg, m_lin, m_text, m_bg, m_border});
    chk("keycode", keycode, e_kc);
    chk("keypress_strobe", keypress_strobe, m_kp);
    chk("key_ready", key_ready, m_ready);
    chk("nogs_iigs", {n_bits[20:17], n_text, n_bg, n_border}, {4'b0, 4'hF, 4'h6, 4'h6});
  endtask

  // One clock of stimulus, model update and full comparison
  task automatic cyc(input logic s, input logic [15:0] a, input logic [7:0] d,
                     input logic rw, input logic kv, input logic [6:0] kc);
    @(negedge clk);
    stb = s; addr = a; data = d; rw_n = rw; key_valid = kv; key_code = kc;
    @(posedge clk);
    model_step(s, a, d, rw, kv, kc);
    #1;
    stb = 1'b0; key_valid = 1'b0;
    compare_all();
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
    cyc(1'b1, a, d, 1'b0, 1'b0, 7'd0);
  endtask

  task automatic bus_rd(input logic [15:0] a);
    cyc(1'b1, a, 8'h00, 1'b1, 1'b0, 7'd0);
  endtask

  task automatic key_push(input logic [6:0] k);
    cyc(1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, k);
  endtask

  function automatic logic [15:0] rand_addr();
    logic [15:0] gs[4] = '{16'hC021, 16'hC022, 16'hC029, 16'hC034};
    case ($urandom_range(0, 9))
      0: return 16'hC000 + 16'($urandom_range(0, 15));
      1: return 16'hC010 + 16'($urandom_range(0, 15));
      2: return gs[$urandom_range(0, 3)];
      3: return 16'hC050 + 16'($urandom_range(0, 15));
      4: return 16'hC000 + 16'($urandom_range(1, 7) * 256) + 16'($urandom_range(0, 255));
      5: return 16'hCFFF;
      6: return 16'($urandom_range(0, 16'h01FF));
      7: return 16'h0400 + 16'($urandom_range(0, 16'h03FF));
      8: return 16'h2000 + 16'($urandom_range(0, 16'h1FFF));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1; stb = 1'b0; addr = '0; data = '0; rw_n = 1'b1;
    key_valid = 1'b0; key_code = '0;
    m_reset();
    #2;
    compare_all();
    @(negedge clk);
    rst = 1'b0;

    // Memory-management writes then PAGE2 via reads
    bus_wr(16'hC001, 8'h00);
    bus_wr(16'hC005, 8'h00);
    bus_rd(16'hC054);
    chk("s031_store80", STORE80, 1'b1);
    chk("s031_ramwrt", RAMWRT, 1'b1);
    chk("s031_page2_lo", PAGE2, 1'b0);
    bus_rd(16'hC055);
    chk("s031_page2_hi", PAGE2, 1'b1);

    // IIgs colour register on both instances
    bus_wr(16'hC022, 8'hA5);
    chk("s032_text", TEXT_COLOR, 4'hA);
    chk("s032_bg", BACKGROUND_COLOR, 4'h5);
    chk("s032_nogs_text", n_text, 4'hF);
    chk("s032_nogs_bg", n_bg, 4'h6);

    // Slot ROM claim and release
    bus_rd(16'hC305);
    chk("s033_slotrom", SLOTROM, 3'd3);
    chk("s033_intc8_set", INTC8ROM, 1'b1);
    bus_rd(16'hCFFF);
    chk("s033_intc8_clr", INTC8ROM, 1'b0);

    // Fill the FIFO, then drain it
    key_push(7'h41); key_push(7'h42); key_push(7'h43); key_push(7'h44);
    chk("s034_ready_full", key_ready, 1'b0);
    chk("s034_head", keycode, 8'hC1);
    bus_rd(16'hC010);
    chk("s034_pop1", keycode, 8'hC2);
    chk("s034_strobe1", keypress_strobe, 1'b1);
    bus_wr(16'hC01F, 8'h00);
    chk("s034_pop2", keycode, 8'hC3);
    chk("s034_strobe2", keypress_strobe, 1'b1);
    bus_rd(16'hC018);
    chk("s034_pop3", keycode, 8'hC4);
    chk("s034_strobe3", keypress_strobe, 1'b1);
    bus_rd(16'hC010);
    chk("s034_empty", keycode, 8'h44);
    chk("s034_no_strobe", keypress_strobe, 1'b0);
    bus_rd(16'hC010);
    chk("s034_empty_pop", keycode, 8'h44);

    // Simultaneous push and pop with one entry queued
    key_push(7'h60);
    cyc(1'b1, 16'hC010, 8'h00, 1'b1, 1'b1, 7'h5A);
    chk("s035_keycode", keycode, 8'hDA);
    chk("s035_strobe", keypress_strobe, 1'b1);
    bus_rd(16'hC010);
    chk("s035_drained", keycode, 8'h5A);

    // Asynchronous reset with keys queued and PAGE2 set, access in flight
    bus_wr(16'hC055, 8'h00);
    key_push(7'h31); key_push(7'h32); key_push(7'h33);
    chk("s036_pre_kc", keycode, 8'hB1);
    @(negedge clk);
    stb = 1'b1; addr = 16'hC054; rw_n = 1'b1;
    rst = 1'b1;
    #1;
    chk("s036_keycode", keycode, 8'h00);
    chk("s036_page2", PAGE2, 1'b0);
    chk("s036_text", TEXT_MODE, 1'b1);
    chk("s036_ready", key_ready, 1'b1);
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; stb = 1'b0;
    #1;
    compare_all();
    bus_rd(16'hC055);
    chk("s036_first_access", PAGE2, 1'b1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 3) != 0), rand_addr(), 8'($urandom), 1'($urandom),
          ($urandom_range(0, 4) == 0), 7'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
